alu_operand_fetch: RTL

- Issue stage directly upstream of the ALU. Accepts 16-bit instruction words over a valid/ready handshake.
- Reads two source operands from an internal 16x16 register file, with same-cycle writeback bypass.
- Holds back instructions with read-after-write hazards using a pending-write scoreboard.
- Presents registered operation/input1/input2 to the ALU. ALU results return through the writeback port.

---
 rtl/isa_pkg.sv | 40 ++++
 rtl/alu_regfile.sv | 29 ++
 rtl/alu_operand_fetch.sv | 88 ++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Instruction-set constants and field layout shared by the issue stage and its register file.
package isa_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int REG_W  = 4;

  localparam logic [3:0] NOP_OPC = 4'b0000;
  localparam logic [3:0] ADD_OPC = 4'b0001;
  localparam logic [3:0] SUB_OPC = 4'b0010;
  localparam logic [3:0] AND_OPC = 4'b0011;
  localparam logic [3:0] OR_OPC  = 4'b0100;
  localparam logic [3:0] XOR_OPC = 4'b0101;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 0;

  typedef struct packed {
    logic [3:0]       opc;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } instr_t;

  function automatic instr_t decode(input logic [DATA_W-1:0] w);
    instr_t d;
    d.opc = w[OPC_HI:OPC_LO];
    d.rd  = w[RD_HI:RD_LO];
    d.rs  = w[RS_HI:RS_LO];
    d.rt  = w[RT_HI:RT_LO];
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16x16 register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
module alu_regfile
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  i_ra,
  input  logic [REG_W-1:0]  i_rb,
  output logic [DATA_W-1:0] o_da,
  output logic [DATA_W-1:0] o_db,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [NREGS-1:0][DATA_W-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_da = (i_ra == '0) ? '0 : r_mem[i_ra];
  assign o_db = (i_rb == '0) ? '0 : r_mem[i_rb];

endmodule

// File: rtl/alu_operand_fetch.sv
// ALU issue stage: operand read with writeback bypass, RAW scoreboard, and a one-deep output register.
module alu_operand_fetch
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] operation,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2
);

  instr_t            w_ins;
  logic [DATA_W-1:0] w_rf_rs, w_rf_rt;
  logic [DATA_W-1:0] w_op_rs, w_op_rt;
  logic              w_haz_rs, w_haz_rt, w_hazard, w_accept;
  logic [NREGS-1:0]  w_pend_nxt;

  logic [NREGS-1:0]  r_pend;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_operation, r_input1, r_input2;

  assign w_ins = decode(in_instr);

  alu_regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ra  (w_ins.rs),
    .i_rb  (w_ins.rt),
    .o_da  (w_rf_rs),
    .o_db  (w_rf_rt),
    .i_we  (wb_en),
    .i_wa  (wb_addr),
    .i_wd  (wb_data)
  );

  // r0 needs no bypass: the array read already forces it to zero.
  assign w_op_rs = (wb_en && (wb_addr == w_ins.rs) && (w_ins.rs != '0)) ? wb_data : w_rf_rs;
  assign w_op_rt = (wb_en && (wb_addr == w_ins.rt) && (w_ins.rt != '0)) ? wb_data : w_rf_rt;

  // A pending register retiring this cycle is not a hazard; the bypass covers it.
  assign w_haz_rs = (w_ins.rs != '0) && r_pend[w_ins.rs] && !(wb_en && (wb_addr == w_ins.rs));
  assign w_haz_rt = (w_ins.rt != '0) && r_pend[w_ins.rt] && !(wb_en && (wb_addr == w_ins.rt));
  assign w_hazard = in_valid && (w_haz_rs || w_haz_rt);

  assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
  assign w_accept = in_valid && in_ready;

  // Clear first, then set: a new issue to the retiring register keeps it pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_en) w_pend_nxt[wb_addr] = 1'b0;
    if (w_accept && (w_ins.opc != NOP_OPC) && (w_ins.rd != '0)) w_pend_nxt[w_ins.rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_out_valid <= 1'b0;
      r_operation <= '0;
      r_input1    <= '0;
      r_input2    <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_operation <= in_instr;
        r_input1    <= w_op_rs;
        r_input2    <= w_op_rt;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign operation = r_operation;
  assign input1    = r_input1;
  assign input2    = r_input2;

endmodule
